vedic_mac_sequencer: RTL
========================

Name: vedic_mac_sequencer

Overview:
- Sequences one shared 8x8 vedic multiplier (instantiated outside this block) across NTAPS filter taps to form one FIR/LMS output sum y = sum(x[i]*w[i]).
- Drives the tap address to the sample and coefficient memories, registers the operands into the multiplier, and accumulates the products.
- Reports the result with a start/busy/done handshake.
- Sits between the filter's sample/coefficient stores and the multiplier datapath in the adaptive filter.

Parameters:
NTAPS, 8, taps per output sample; range 2..256.
AW, 3, tap address width; must equal clog2(NTAPS).
ACCW, 20, accumulator width; must be at least 17+AW.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request one output computation; sampled only in IDLE.
busy  output  1  high while a computation is in progress.
done  output  1  one-cycle pulse; acc_out is valid in this cycle.
tap_addr  output  AW  read address for sample and coefficient memories.
x_data  input  8  sample read data; valid one cycle after tap_addr.
w_data  input  8  coefficient read data; valid one cycle after tap_addr.
mul_a  output  8  registered multiplier operand A (sample).
mul_b  output  8  registered multiplier operand B (coefficient).
mul_p  input  16  combinational product from the external multiplier for mul_a*mul_b.
acc_out  output  ACCW  accumulated sum; holds its value until the next accepted start.

Behaviour:
- Reset is synchronous and active-low. When rst_n is low at a clock edge:
  - state goes to IDLE.
  - busy=0, done=0, tap_addr=0, mul_a=0, mul_b=0, acc_out=0.
  - The pipeline valid bits are cleared.
- The reset takes precedence over every other event, including in mid-run. An aborted run never produces done.
- State machine:
  - IDLE: if start=1 at edge E0, go to RUN. At that edge set tap_addr=0, clear the accumulator and set busy=1. If start=0, stay in IDLE.
  - RUN: tap_addr increments by 1 at each edge. After tap_addr=NTAPS-1 has been presented, go to DRAIN and hold tap_addr at NTAPS-1.
  - DRAIN: wait for the two pipeline stages to empty, then return to IDLE.
- Pipeline for the tap issued at edge Ek:
  - x_data/w_data are valid during the cycle after Ek+1.
  - mul_a/mul_b are loaded at Ek+2.
  - mul_p is added into the accumulator at Ek+3.
  - Valid bits travel with each stage. Only valid stages load the operands or accumulate.
- Latency:
  - The last accumulate happens at edge E(NTAPS+2). At that same edge busy goes to 0 and done goes to 1 for one cycle.
  - start to done is NTAPS+2 cycles; for NTAPS=8 that is 10 cycles.
- Arithmetic:
  - Products are zero-extended to ACCW and summed.
  - Overflow wraps modulo 2^ACCW. With the parameter rule above, overflow cannot occur in unsigned mode.
- Handshake boundaries:
  - start while busy=1 is ignored and not queued.
  - start during the done cycle is accepted, because the state is IDLE. That gives back-to-back runs with no idle gap. acc_out clears at that edge, so done/acc_out must be captured during the done cycle.
  - start held high continuously re-triggers on every IDLE cycle.
- Between runs, mul_a and mul_b hold their last values.

Optional Feature:
- Macro: VEDIC_MAC_SIGNED_EN.
- When the macro is defined:
  - x_data and w_data are two's complement.
  - The operand stage loads mul_a=|x| and mul_b=|w|; -128 gives magnitude 128 (0x80).
  - A sign bit, x[7]^w[7], is pipelined alongside the operands.
  - The accumulate stage adds -mul_p (sign-extended) when the sign bit is set, otherwise +mul_p.
  - acc_out is two's complement.
- When the macro is undefined: operands are unsigned, passed through unchanged, and there is no sign logic.
- Latency is identical in both modes.

Test Plan:
1. Unsigned, NTAPS=8, x[i]=255, w[i]=255; pulse start -> done exactly 10 cycles after the start edge, acc_out=520200 (0x7F008), busy high for exactly 10 cycles.
2. Unsigned ramp x[i]=i, w[i]=i+1 -> acc_out=168. tap_addr sequence is 0..7 on consecutive cycles, and each mul_a/mul_b pair lags its address by 2 cycles.
3. start pulsed again 3 cycles into a run -> ignored: a single done at cycle 10, acc_out unchanged from the single-run value.
4. start asserted during the done cycle with a new memory pattern (x[i]=1, w[i]=2) -> second done 10 cycles later with acc_out=16, and no idle cycle between the runs.
5. rst_n low for 1 cycle at cycle 5 of a run -> all outputs 0 on the next cycle and no done. A fresh start afterwards completes normally.
6. VEDIC_MAC_SIGNED_EN defined, x[i]=0xFD (-3), w[i]=5 -> mul_a=3, mul_b=5, acc_out=0xFFF88 (-120). Also x=0x80, w=0x80 on all taps -> acc_out=131072.

Source files
------------

// File: rtl/vedic_mac_sequencer.sv
// vedic_mac_sequencer: time-multiplexes one external 8x8 multiplier over NTAPS taps, accumulating y = sum(x[i]*w[i])
// Ports: clk, rst_n (sync, active-low) | start in, busy/done out (done is a 1-cycle pulse, acc_out valid then)
//        tap_addr -> sample/coeff memories, x_data/w_data <- memories one cycle later
//        mul_a/mul_b -> registered multiplier operands, mul_p <- combinational product
//        acc_out: running sum, held until the next accepted start
// Build option: define VEDIC_MAC_SIGNED_EN for two's complement x/w (magnitudes to the multiplier, sign applied at accumulate)
module vedic_mac_sequencer #(
  parameter int NTAPS = 8,
  parameter int AW    = 3,
  parameter int ACCW  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   tap_addr,
  input  logic [7:0]      x_data,
  input  logic [7:0]      w_data,
  output logic [7:0]      mul_a,
  output logic [7:0]      mul_b,
  input  logic [15:0]     mul_p,
  output logic [ACCW-1:0] acc_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  state_t state, state_nx;
  logic v_data, v_op, last_tap, fin, go;
  logic [7:0] a_nx, b_nx;
  logic [ACCW-1:0] prod;
  assign last_tap = tap_addr == LAST;
  // v_data: memory output is valid; v_op: mul_a/mul_b hold a live tap
  assign fin = state == DRAIN && v_op && !v_data;
  assign go = state == IDLE && start;
`ifdef VEDIC_MAC_SIGNED_EN
  logic sgn;
  assign a_nx = x_data[7] ? -x_data : x_data;
  assign b_nx = w_data[7] ? -w_data : w_data;
  assign prod = sgn ? -ACCW'(mul_p) : ACCW'(mul_p);
`else
  assign a_nx = x_data;
  assign b_nx = w_data;
  assign prod = ACCW'(mul_p);
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last_tap ? DRAIN : RUN) :
               state == DRAIN ? (fin ? IDLE : DRAIN) : IDLE;
  always_comb busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      done     <= 1'b0;
      tap_addr <= '0;
      v_data   <= 1'b0;
      v_op     <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      acc_out  <= '0;
`ifdef VEDIC_MAC_SIGNED_EN
      sgn      <= 1'b0;
`endif
    end else begin
      done   <= fin;
      v_data <= state == RUN;
      v_op   <= v_data;
      if (go) tap_addr <= '0;
      else if (state == RUN && !last_tap) tap_addr <= tap_addr + 1'b1;
      if (v_data) begin
        mul_a <= a_nx;
        mul_b <= b_nx;
`ifdef VEDIC_MAC_SIGNED_EN
        sgn   <= x_data[7] ^ w_data[7];
`endif
      end
      if (go) acc_out <= '0;
      else if (v_op) acc_out <= acc_out + prod;
    end
endmodule
